// File: rtl/pipe_ctrl_chain_if.sv
// pipe_ctrl_chain_if
// Bundles the control-word pipeline signals between the ID stage and the
// pipe_ctrl_chain block.
//   master : ID/control side. It drives ctrl_in, valid_in, hazard, stall and
//            flush. It observes in_ready, stage_ctrl, stage_valid and the
//            two performance counters.
//   slave  : pipe_ctrl_chain itself. It has the opposite directions.
interface pipe_ctrl_chain_if #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 16
);
    logic [CTRL_W-1:0]        ctrl_in;
    logic                     valid_in;
    logic                     hazard;
    logic [STAGES-1:0]        stall;
    logic [STAGES-1:0]        flush;
    logic                     in_ready;
    logic [STAGES*CTRL_W-1:0] stage_ctrl;
    logic [STAGES-1:0]        stage_valid;
    logic [CNT_W-1:0]         retire_cnt;
    logic [CNT_W-1:0]         bubble_cnt;

    modport master (
        output ctrl_in, valid_in, hazard, stall, flush,
        input  in_ready, stage_ctrl, stage_valid, retire_cnt, bubble_cnt
    );

    modport slave (
        input  ctrl_in, valid_in, hazard, stall, flush,
        output in_ready, stage_ctrl, stage_valid, retire_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
// Carries the decoded control word from the ID stage through STAGES pipeline
// registers (EX, MEM, WB, ...). It supports the following features:
//   - hazard bubble insertion at stage 0
//   - per-stage stall, with a bubble injected below the stalled region
//   - per-stage flush
// It also counts retired instructions and bubble-inserting cycles. Both
// counters saturate instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : pipe_ctrl_chain_if.slave, carrying these signals:
//           ctrl_in/valid_in/hazard/stall/flush in
//           in_ready/stage_ctrl/stage_valid/retire_cnt/bubble_cnt out
module pipe_ctrl_chain #(
    parameter int unsigned       CTRL_W    = 10,
    parameter int unsigned       STAGES    = 3,
    parameter logic [CTRL_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_ctrl_chain_if.slave bus
);
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] hold;
    logic              retire_ev;
    logic              bubble_ev;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [CNT_W-1:0]  retire_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;

    // A stall anywhere at or below stage k freezes stage k.
    always_comb begin : hold_logic
        hold = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            hold[k] = |(bus.stall >> k);
        end
    end

    always_comb begin : next_state
        for (int unsigned k = 0; k < STAGES; k++) begin
            ctrl_d[k] = ctrl_q[k];
        end
        valid_d = valid_q;

        // Stage 0: an invalid word is forced to NOP_VALUE. As a result, an
        // invalid stage always holds NOP_VALUE further down the chain.
        if (bus.flush[0]) begin
            ctrl_d[0]  = NOP_VALUE;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            if (bus.hazard || !bus.valid_in) begin
                ctrl_d[0]  = NOP_VALUE;
                valid_d[0] = 1'b0;
            end else begin
                ctrl_d[0]  = bus.ctrl_in;
                valid_d[0] = 1'b1;
            end
        end

        for (int unsigned k = 1; k < STAGES; k++) begin
            if (bus.flush[k]) begin
                ctrl_d[k]  = NOP_VALUE;
                valid_d[k] = 1'b0;
            end else if (!hold[k]) begin
                // The first stage below a held region takes a bubble.
                if (hold[k-1]) begin
                    ctrl_d[k]  = NOP_VALUE;
                    valid_d[k] = 1'b0;
                end else begin
                    ctrl_d[k]  = ctrl_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    always_comb begin : counters
        retire_ev = valid_q[STAGES-1] & ~bus.stall[STAGES-1] & ~bus.flush[STAGES-1];

        bubble_ev = bus.hazard & bus.valid_in & ~hold[0] & ~bus.flush[0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            bubble_ev = bubble_ev | (hold[k-1] & ~hold[k] & ~bus.flush[k]);
        end

        retire_cnt_d = retire_cnt_q;
        if (retire_ev && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end

        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ev && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= NOP_VALUE;
            end
            valid_q      <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            valid_q      <= valid_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    always_comb begin : pack_outputs
        bus.stage_ctrl = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            bus.stage_ctrl[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        end
    end

    assign bus.in_ready    = ~hold[0];
    assign bus.stage_valid = valid_q;
    assign bus.retire_cnt  = retire_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb_pipe_ctrl_chain
// Drives two pipe_ctrl_chain instances with identical stimulus:
//   - u_dut uses CNT_W=16
//   - u_sat uses CNT_W=4, which exercises counter saturation
// A behavioural model tracks the expected contents of each stage. It also
// keeps the true, unbounded event counts. Every cycle, both instances are
// compared against the model. Directed scenarios add literal expectations
// on top of that.
module tb_pipe_ctrl_chain;
    logic       clk;
    logic       rst;
    logic [9:0] ci;
    logic       vi;
    logic       hz;
    logic [2:0] st;
    logic [2:0] fl;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl_chain_if #(.CTRL_W(10), .STAGES(3), .CNT_W(16)) ifc_m ();
    pipe_ctrl_chain_if #(.CTRL_W(10), .STAGES(3), .CNT_W(4))  ifc_s ();

    assign ifc_m.ctrl_in  = ci;
    assign ifc_m.valid_in = vi;
    assign ifc_m.hazard   = hz;
    assign ifc_m.stall    = st;
    assign ifc_m.flush    = fl;
    assign ifc_s.ctrl_in  = ci;
    assign ifc_s.valid_in = vi;
    assign ifc_s.hazard   = hz;
    assign ifc_s.stall    = st;
    assign ifc_s.flush    = fl;

    pipe_ctrl_chain #(.CTRL_W(10), .STAGES(3), .NOP_VALUE(10'h000), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc_m.slave)
    );

    pipe_ctrl_chain #(.CTRL_W(10), .STAGES(3), .NOP_VALUE(10'h000), .CNT_W(4)) u_sat (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: the word held in each stage, plus true (unbounded) counts.
    logic [9:0] m_c [3];
    bit         m_v [3];
    int         r_tot;
    int         b_tot;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Advance the model across one rising edge, using the inputs seen at
    // that edge.
    task automatic model_update();
        logic [9:0] nc [3];
        bit         nv [3];
        int         top;
        bit         bub;
        bit         ret;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_c[k] = '0;
                m_v[k] = 1'b0;
            end
            r_tot = 0;
            b_tot = 0;
            return;
        end
        // Deepest stalled stage. Every stage at or above it is frozen.
        top = -1;
        for (int j = 0; j < 3; j++) if (st[j]) top = j;
        ret = m_v[2] && !st[2] && !fl[2];
        bub = hz && vi && (top < 0) && !fl[0];
        if (top >= 0 && top < 2 && !fl[top+1]) bub = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (fl[k]) begin
                nc[k] = '0; nv[k] = 1'b0;
            end else if (k <= top) begin
                nc[k] = m_c[k]; nv[k] = m_v[k];
            end else if (k == 0) begin
                nv[k] = vi && !hz;
                nc[k] = nv[k] ? ci : 10'h000;
            end else if (k - 1 == top) begin
                nc[k] = '0; nv[k] = 1'b0;
            end else begin
                nc[k] = m_c[k-1]; nv[k] = m_v[k-1];
            end
        end
        for (int k = 0; k < 3; k++) begin
            m_c[k] = nc[k];
            m_v[k] = nv[k];
        end
        if (ret) r_tot++;
        if (bub) b_tot++;
    endtask

    task automatic compare_all();
        logic [29:0] exp_ctrl;
        logic [2:0]  exp_v;
        exp_ctrl = {m_c[2], m_c[1], m_c[0]};
        exp_v    = {m_v[2], m_v[1], m_v[0]};
        chk("stage_ctrl", 64'(ifc_m.stage_ctrl), 64'(exp_ctrl));
        chk("stage_valid", 64'(ifc_m.stage_valid), 64'(exp_v));
        chk("in_ready", 64'(ifc_m.in_ready), 64'(~|st));
        chk("retire_cnt", 64'(ifc_m.retire_cnt), 64'(sat(r_tot, 65535)));
        chk("bubble_cnt", 64'(ifc_m.bubble_cnt), 64'(sat(b_tot, 65535)));
        chk("sat_stage_ctrl", 64'(ifc_s.stage_ctrl), 64'(exp_ctrl));
        chk("sat_retire_cnt", 64'(ifc_s.retire_cnt), 64'(sat(r_tot, 15)));
        chk("sat_bubble_cnt", 64'(ifc_s.bubble_cnt), 64'(sat(b_tot, 15)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [9:0] c, input logic v, input logic h,
                         input logic [2:0] s, input logic [2:0] f);
        ci = c; vi = v; hz = h; st = s; fl = f;
    endtask

    initial begin
        rst = 1'b1;
        drive(10'h3FF, 1'b1, 1'b0, 3'b000, 3'b000);

        // Reset overrides a valid input.
        cycle(); cycle();
        chk("rst_ctrl", 64'(ifc_m.stage_ctrl), 64'h0);
        chk("rst_valid", 64'(ifc_m.stage_valid), 64'h0);
        chk("rst_retire", 64'(ifc_m.retire_cnt), 64'h0);
        chk("rst_bubble", 64'(ifc_m.bubble_cnt), 64'h0);

        // A single word walks through the pipe with one stage per edge.
        rst = 1'b0;
        drive(10'h015, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        chk("t1_s0", 64'(ifc_m.stage_ctrl), 64'h0000015);
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000); cycle();
        chk("t1_s1", 64'(ifc_m.stage_ctrl), 64'h0005400);
        cycle();
        chk("t1_s2", 64'(ifc_m.stage_ctrl), 64'h1500000);
        cycle();
        chk("t1_retire", 64'(ifc_m.retire_cnt), 64'd1);

        // A hazard on B turns B into a bubble.
        drive(10'h001, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h002, 1'b1, 1'b1, 3'b000, 3'b000); cycle();
        drive(10'h003, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        chk("t2_ctrl", 64'(ifc_m.stage_ctrl), 64'h0100003);
        chk("t2_valid", 64'(ifc_m.stage_valid), 64'b101);
        chk("t2_bubble", 64'(ifc_m.bubble_cnt), 64'd1);
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        repeat (3) cycle();
        chk("t2_retire", 64'(ifc_m.retire_cnt), 64'd3);

        // Stall stage 1 for two cycles; stage 2 receives two bubbles.
        drive(10'h011, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h012, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h013, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h014, 1'b1, 1'b0, 3'b010, 3'b000);
        #1 chk("t3_in_ready", 64'(ifc_m.in_ready), 64'd0);
        cycle(); cycle();
        chk("t3_frozen", 64'(ifc_m.stage_ctrl), 64'h0004813);
        chk("t3_valid", 64'(ifc_m.stage_valid), 64'b011);
        chk("t3_bubble", 64'(ifc_m.bubble_cnt), 64'd3);
        chk("t3_retire", 64'(ifc_m.retire_cnt), 64'd4);
        drive(10'h014, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        chk("t3_resume", 64'(ifc_m.stage_ctrl), 64'h1204C14);
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        repeat (3) cycle();
        chk("t3_drain_retire", 64'(ifc_m.retire_cnt), 64'd7);
        chk("t3_drain_valid", 64'(ifc_m.stage_valid), 64'b000);

        // Flush stages 0 and 1 while the stages hold A, B, C.
        drive(10'h023, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h022, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h021, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b011); cycle();
        chk("t4_ctrl", 64'(ifc_m.stage_ctrl), 64'h2200000);
        chk("t4_valid", 64'(ifc_m.stage_valid), 64'b100);
        chk("t4_bubble", 64'(ifc_m.bubble_cnt), 64'd3);
        chk("t4_retire_c", 64'(ifc_m.retire_cnt), 64'd8);
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000); cycle();
        chk("t4_retire_b", 64'(ifc_m.retire_cnt), 64'd9);

        // Stall beats hazard at stage 0, then reset lands mid-stall.
        drive(10'h031, 1'b1, 1'b0, 3'b000, 3'b000); cycle();
        drive(10'h032, 1'b1, 1'b1, 3'b001, 3'b000);
        #1 chk("t5_in_ready", 64'(ifc_m.in_ready), 64'd0);
        cycle();
        chk("t5_s0_kept", 64'(ifc_m.stage_ctrl[9:0]), 64'h031);
        chk("t5_s0_valid", 64'(ifc_m.stage_valid[0]), 64'd1);
        drive(10'h033, 1'b1, 1'b1, 3'b111, 3'b000); cycle();
        chk("t5_bubble_held", 64'(ifc_m.bubble_cnt), 64'd4);
        rst = 1'b1;
        drive(10'h000, 1'b0, 1'b0, 3'b100, 3'b000); cycle();
        chk("t5_rst_ctrl", 64'(ifc_m.stage_ctrl), 64'h0);
        chk("t5_rst_valid", 64'(ifc_m.stage_valid), 64'h0);
        chk("t5_rst_retire", 64'(ifc_m.retire_cnt), 64'h0);
        chk("t5_rst_bubble", 64'(ifc_m.bubble_cnt), 64'h0);
        rst = 1'b0;
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);

        // Twenty back-to-back instructions saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive(10'($urandom), 1'b1, 1'b0, 3'b000, 3'b000);
            cycle();
        end
        drive(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        repeat (3) cycle();
        chk("t6_retire16", 64'(ifc_m.retire_cnt), 64'd20);
        chk("t6_retire4", 64'(ifc_s.retire_cnt), 64'hF);
        cycle();
        chk("t6_retire4_hold", 64'(ifc_s.retire_cnt), 64'hF);

        // Random traffic, checked against the model every cycle.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(10'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0),
                  3'($urandom) & 3'($urandom) & 3'($urandom),
                  3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
